param_fifo: RTL and testbench
=============================

Name: param_fifo

Overview:
Parametrised synchronous FIFO, next generation of the transaction-layer buffer; one instance per virtual channel / traffic class.
- Generalised data width and depth.
- Adds a correct full/empty/count model, simultaneous push+pop, and registered read data with a valid strobe.
- Adds runtime almost_full/almost_empty thresholds latched in the INIT state of the link state machine.
- Sits between the transaction-layer state machine and downstream arbiters.

Parameters:
DATA_W, 10, width of each entry in bits
DEPTH, 8, number of entries; power of two, minimum 4
ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden
AF_DEFAULT, DEPTH-2, almost_full threshold used after reset until INIT latches one
AE_DEFAULT, 1, almost_empty threshold used after reset until INIT latches one

Ports:
clk  input  1  clock; all logic on posedge
reset_L  input  1  asynchronous, active-low reset
state  input  4  link state code from the state machine (fifo_pkg codes)
push  input  1  write request
pop  input  1  read request
data_in  input  DATA_W  write data
umbral_superior  input  ADDR_W+1  almost_full threshold, sampled in INIT
umbral_inferior  input  ADDR_W+1  almost_empty threshold, sampled in INIT
data_out  output  DATA_W  read data, registered
valid_out  output  1  data_out holds a newly popped word this cycle
count  output  ADDR_W+1  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= latched upper threshold
almost_empty  output  1  count <= latched lower threshold

Behaviour:
- Reset is asynchronous (reset_L low) with synchronous release.
  - Clears wr_ptr, rd_ptr, count, data_out and valid_out to 0.
  - empty=1, full=0, almost_empty=1, almost_full=0.
  - Threshold registers load AF_DEFAULT and AE_DEFAULT.
- state==STATE_RESET acts as a synchronous flush: same values as async reset, except the thresholds keep their value. RAM contents are don't-care.
- state==STATE_INIT: each cycle, upper/lower threshold registers load umbral_superior/umbral_inferior. Push and pop are still honoured.
- Push is accepted iff push && !full. The entry is written at wr_ptr, and wr_ptr increments modulo DEPTH (natural ADDR_W wrap).
- Pop is accepted iff pop && !empty. RAM[rd_ptr] is registered to data_out, valid_out=1 on the next cycle, and rd_ptr increments modulo DEPTH.
  - If no pop was accepted, valid_out=0 and data_out holds its last value.
- Read latency: one clock from accepted pop to valid_out.
- Push and pop in the same cycle:
  - Both qualified independently against the pre-cycle full/empty.
  - When both are accepted, count is unchanged.
  - Push on full with pop: the push is rejected, the pop proceeds, and count decrements.
  - Pop on empty with push: the pop is rejected; the word becomes readable the next cycle.
- count: +1 on push only, -1 on pop only, held otherwise. Never exceeds DEPTH and never underflows.
- full, empty, almost_full and almost_empty are registered and derived from the next count, so they are coherent with count in the same cycle.
- A rejected push or pop has no state effect; the data is dropped silently unless FIFO_ERR_EN is defined.
- Threshold compare is unsigned, ADDR_W+1 bits.
  - A threshold of 0 makes almost_full permanently 1 (almost_full is count >= threshold).
  - A threshold of DEPTH makes almost_empty permanently 1 (almost_empty is count <= threshold).
- Reset mid-operation: all outputs take their reset values immediately, and a pending valid_out is squashed.

Optional Feature:
FIFO_ERR_EN:
- Defined: adds output ports overflow (1) and underflow (1), both sticky.
  - overflow is set on a rejected push; underflow is set on a rejected pop.
  - Both are cleared by reset_L or by state==STATE_RESET.
  - The flag rises the cycle after the offending request.
- Undefined: the ports and their logic are absent, and rejected requests are silent.

Decomposition:
- Shared package fifo_pkg holds the state codes: STATE_RESET=4'b0001, STATE_INIT=4'b0010, STATE_IDLE=4'b0100, STATE_ACTIVE=4'b1000.
- One sub-module, fifo_dpram: simple dual-port RAM, parameters DATA_W and DEPTH.
  - Write port: synchronous write.
  - Read port: synchronous read with enable.
  - No reset on the storage array.

Test Plan:
- Reset and INIT (DATA_W=10, DEPTH=8): assert reset_L=0 -> empty=1, count=0, almost_empty=1, valid_out=0. Release, hold STATE_INIT with umbral_superior=6 and umbral_inferior=2 -> thresholds latched.
- Fill and drain: push 8 words 0x001..0x008.
  - almost_full at count 6 and full at count 8; a 9th push is ignored and count stays 8.
  - Pop 8 -> data_out 0x001..0x008 in order, each one cycle after its pop; empty=1 at the end.
- Wrap-around: repeat push 5 / pop 5 three times -> pointers wrap past 7, data order is preserved, count returns to 0.
- Simultaneous push and pop:
  - At count=3, push+pop -> count stays 3 and the oldest word is output.
  - At full, push+pop -> count=7.
  - At empty, push+pop -> count=1 and valid_out=0.
- Soft flush: at count=5, drive state=STATE_RESET for 1 cycle -> count=0, empty=1, and the thresholds are still 6/2.
- FIFO_ERR_EN: pop on empty -> underflow=1 the next cycle and sticky. Push on full -> overflow=1. STATE_RESET clears both.

Source files
------------

// File: rtl/param_fifo_pkg.sv
// Shared definitions for the transaction-layer FIFO (package fifo_pkg).
// Contents:
//   link_state_e - one-hot link state codes driven by the transaction-layer
//                  state machine onto the FIFO's 4-bit state input.
package fifo_pkg;

  typedef enum logic [3:0] {
    STATE_RESET  = 4'b0001,
    STATE_INIT   = 4'b0010,
    STATE_IDLE   = 4'b0100,
    STATE_ACTIVE = 4'b1000
  } link_state_e;

  localparam int STATE_W = 4;

endpackage

// File: rtl/param_fifo_if.sv
// Handshake bundle between the FIFO and its producer/consumer.
// Parameters: DATA_W (entry width), DEPTH (entries, power of two).
// Signals:
//   push, pop, data_in        - requests and write data (master -> FIFO)
//   data_out, valid_out       - registered read data and its strobe
//   count, full, empty,
//   almost_full, almost_empty - occupancy and status flags
// Modports: master (producer/consumer side), slave (the FIFO).
interface param_fifo_if #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 8
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              push;
  logic              pop;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;

  modport master (
    output push, pop, data_in,
    input  data_out, valid_out, count, full, empty, almost_full, almost_empty
  );

  modport slave (
    input  push, pop, data_in,
    output data_out, valid_out, count, full, empty, almost_full, almost_empty
  );

endinterface

// File: rtl/param_fifo_dpram.sv
// Simple dual-port RAM backing the FIFO (module fifo_dpram).
// Parameters: DATA_W, DEPTH.
// Ports:
//   clk            - clock
//   reset_L        - async active-low reset of the read register only
//   clr            - synchronous clear of the read register
//   we/waddr/wdata - synchronous write port
//   re/raddr/rdata - synchronous read port with enable; rdata holds when re=0
// The storage array itself is never reset.
module fifo_dpram #(
  parameter  int DATA_W = 10,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // read stage: RAM word -> registered output
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)  rdata <= '0;
    else if (clr)  rdata <= '0;
    else if (re)   rdata <= mem[raddr];
  end

endmodule

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO for one virtual channel / traffic class.
// Parameters: DATA_W, DEPTH (power of two, >= 4), AF_DEFAULT, AE_DEFAULT;
//             ADDR_W is derived from DEPTH.
// Ports:
//   clk, reset_L     - clock and async active-low reset
//   state            - link state code (fifo_pkg); STATE_RESET flushes,
//                      STATE_INIT loads the almost_full/almost_empty thresholds
//   umbral_superior  - almost_full threshold, sampled while in INIT
//   umbral_inferior  - almost_empty threshold, sampled while in INIT
//   fifo             - param_fifo_if.slave handshake bundle
//   overflow,
//   underflow        - sticky error flags, present only with FIFO_ERR_EN
// Build option: define FIFO_ERR_EN to add the sticky error flags.
module param_fifo
  import fifo_pkg::*;
#(
  parameter  int DATA_W     = 10,
  parameter  int DEPTH      = 8,
  localparam int ADDR_W     = $clog2(DEPTH),
  parameter  int AF_DEFAULT = DEPTH - 2,
  parameter  int AE_DEFAULT = 1
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic [STATE_W-1:0] state,
  input  logic [ADDR_W:0]    umbral_superior,
  input  logic [ADDR_W:0]    umbral_inferior,
  param_fifo_if.slave        fifo
`ifdef FIFO_ERR_EN
  ,
  output logic               overflow,
  output logic               underflow
`endif
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_DEFAULT);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_DEFAULT);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_r, count_nxt;
  logic [ADDR_W:0]   af_thr, ae_thr, af_thr_nxt, ae_thr_nxt;
  logic              full_r, empty_r, af_r, ae_r;
  logic              vld_p1;
  logic [DATA_W-1:0] rd_data_p1;
  logic              flush, push_ok, pop_ok;

  // Occupancy update; callers only assert inc when not full and dec when
  // not empty, so the result stays within 0..DEPTH.
  function automatic logic [ADDR_W:0] occ_next(input logic [ADDR_W:0] c,
                                               input logic inc,
                                               input logic dec);
    case ({inc, dec})
      2'b10:   return c + 1'b1;
      2'b01:   return c - 1'b1;
      default: return c;
    endcase
  endfunction

  // Requests are qualified against the flags as they stood before this edge.
  // A flush cycle discards any request outright.
  assign flush   = (state == STATE_RESET);
  assign push_ok = fifo.push && !full_r  && !flush;
  assign pop_ok  = fifo.pop  && !empty_r && !flush;

  // Flags are computed from next-cycle count and thresholds so they are
  // coherent with count on the cycle they become visible.
  always_comb begin
    af_thr_nxt = af_thr;
    ae_thr_nxt = ae_thr;
    if (state == STATE_INIT) begin
      af_thr_nxt = umbral_superior;
      ae_thr_nxt = umbral_inferior;
    end
    count_nxt = flush ? '0 : occ_next(count_r, push_ok, pop_ok);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      af_r    <= 1'b0;
      ae_r    <= 1'b1;
      vld_p1  <= 1'b0;
      af_thr  <= AF_C;
      ae_thr  <= AE_C;
    end else begin
      af_thr  <= af_thr_nxt;
      ae_thr  <= ae_thr_nxt;
      count_r <= count_nxt;
      full_r  <= (count_nxt == DEPTH_C);
      empty_r <= (count_nxt == '0);
      af_r    <= (count_nxt >= af_thr_nxt);
      ae_r    <= (count_nxt <= ae_thr_nxt);
      vld_p1  <= pop_ok;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + ADDR_W'(1);
      end
    end
  end

  // read stage: popped word lands in the RAM read register one clock later
  fifo_dpram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .reset_L (reset_L),
    .clr     (flush),
    .we      (push_ok),
    .waddr   (wr_ptr),
    .wdata   (fifo.data_in),
    .re      (pop_ok),
    .raddr   (rd_ptr),
    .rdata   (rd_data_p1)
  );

  assign fifo.data_out     = rd_data_p1;
  assign fifo.valid_out    = vld_p1;
  assign fifo.count        = count_r;
  assign fifo.full         = full_r;
  assign fifo.empty        = empty_r;
  assign fifo.almost_full  = af_r;
  assign fifo.almost_empty = ae_r;

`ifdef FIFO_ERR_EN
  // Sticky flags; a flush clears them even if a bad request arrives with it.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (fifo.push && full_r) overflow  <= 1'b1;
      if (fifo.pop && empty_r) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_param_fifo.sv
module tb_param_fifo;
  import fifo_pkg::*;

  localparam int DATA_W = 10;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset_L;
  logic [3:0]        state;
  logic [ADDR_W:0]   usup, uinf;
`ifdef FIFO_ERR_EN
  logic              overflow, underflow;
`endif

  always #5 clk = ~clk;

  param_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  param_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .state           (state),
    .umbral_superior (usup),
    .umbral_inferior (uinf),
    .fifo            (bus)
`ifdef FIFO_ERR_EN
    ,
    .overflow        (overflow),
    .underflow       (underflow)
`endif
  );

  // reference model
  int                mcount;
  int                thr_af, thr_ae;
  bit                m_ov, m_un;
  logic [DATA_W-1:0] exp_dout;
  logic [DATA_W-1:0] sb [$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "/count"}, 32'(bus.count), 32'(mcount));
    chk({tag, "/full"},  32'(bus.full),  32'(mcount == DEPTH));
    chk({tag, "/empty"}, 32'(bus.empty), 32'(mcount == 0));
    chk({tag, "/afull"}, 32'(bus.almost_full),  32'(mcount >= thr_af));
    chk({tag, "/aempty"},32'(bus.almost_empty), 32'(mcount <= thr_ae));
`ifdef FIFO_ERR_EN
    chk({tag, "/overflow"},  32'(overflow),  32'(m_ov));
    chk({tag, "/underflow"}, 32'(underflow), 32'(m_un));
`endif
  endtask

  task automatic model_reset();
    mcount   = 0;
    thr_af   = DEPTH - 2;
    thr_ae   = 1;
    m_ov     = 0;
    m_un     = 0;
    exp_dout = '0;
    sb.delete();
  endtask

  // One clock of stimulus; expected words enter the scoreboard when driven
  // and leave it when the DUT strobes valid_out.
  task automatic step(input string tag, input bit p, input bit q,
                      input logic [DATA_W-1:0] d, input logic [3:0] st);
    bit fl, ap, aq;
    fl = (st == STATE_RESET);
    ap = p && (mcount < DEPTH) && !fl;
    aq = q && (mcount > 0) && !fl;
    bus.push    = p;
    bus.pop     = q;
    bus.data_in = d;
    state       = st;
    if (ap) sb.push_back(d);
    @(posedge clk);
    #1;
    if (fl) begin
      mcount   = 0;
      m_ov     = 0;
      m_un     = 0;
      exp_dout = '0;
      sb.delete();
    end else begin
      if (p && mcount == DEPTH) m_ov = 1;
      if (q && mcount == 0)     m_un = 1;
      mcount = mcount + int'(ap) - int'(aq);
    end
    if (st == STATE_INIT) begin
      thr_af = int'(usup);
      thr_ae = int'(uinf);
    end
    chk({tag, "/valid"}, 32'(bus.valid_out), 32'(aq));
    if (bus.valid_out === 1'b1 && sb.size() > 0) exp_dout = sb.pop_front();
    chk({tag, "/data"}, 32'(bus.data_out), 32'(exp_dout));
    check_flags(tag);
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  initial begin
    reset_L     = 1'b1;
    state       = STATE_IDLE;
    usup        = '0;
    uinf        = '0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = '0;

    // async reset
    #3 reset_L = 1'b0;
    #1;
    model_reset();
    chk("reset/valid", 32'(bus.valid_out), 32'd0);
    chk("reset/data",  32'(bus.data_out),  32'd0);
    check_flags("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) reset_L = 1'b1;

    // INIT latches 6/2; later changes on the inputs must be ignored
    usup = 4'd6;
    uinf = 4'd2;
    step("init", 0, 0, '0, STATE_INIT);
    usup = 4'd3;
    uinf = 4'd5;

    // fill, reject ninth push, drain, pop on empty
    for (int i = 1; i <= DEPTH; i++) step("fill", 1, 0, DATA_W'(i), STATE_ACTIVE);
    step("push_full", 1, 0, 10'h3FF, STATE_ACTIVE);
    for (int i = 0; i < DEPTH; i++) step("drain", 0, 1, '0, STATE_ACTIVE);
    step("idle_out", 0, 0, '0, STATE_IDLE);
    step("pop_empty", 0, 1, '0, STATE_ACTIVE);
    step("sticky", 0, 0, '0, STATE_ACTIVE);

    // wrap-around
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 5; j++) step("wrap_push", 1, 0, DATA_W'(10'h100 + 16*k + j), STATE_ACTIVE);
      for (int j = 0; j < 5; j++) step("wrap_pop", 0, 1, '0, STATE_ACTIVE);
    end

    // simultaneous push + pop at mid, full and empty
    for (int j = 0; j < 3; j++) step("sim_fill", 1, 0, DATA_W'(10'h0A0 + j), STATE_ACTIVE);
    step("sim_mid", 1, 1, 10'h0B0, STATE_ACTIVE);
    for (int j = 0; j < 5; j++) step("sim_fill2", 1, 0, DATA_W'(10'h0C0 + j), STATE_ACTIVE);
    step("sim_full", 1, 1, 10'h2AA, STATE_ACTIVE);
    for (int j = 0; j < 7; j++) step("sim_drain", 0, 1, '0, STATE_ACTIVE);
    step("sim_empty", 1, 1, 10'h155, STATE_ACTIVE);
    step("sim_read", 0, 1, '0, STATE_ACTIVE);

    // soft flush at count 5, thresholds must survive
    for (int j = 0; j < 5; j++) step("pre_flush", 1, 0, DATA_W'(10'h1E0 + j), STATE_ACTIVE);
    step("flush", 1, 1, 10'h3C3, STATE_RESET);
    for (int j = 0; j < 7; j++) step("post_flush", 1, 0, DATA_W'(10'h200 + j), STATE_ACTIVE);
    for (int j = 0; j < 7; j++) step("post_drain", 0, 1, '0, STATE_ACTIVE);

    // threshold extremes: 0 forces almost_full, DEPTH forces almost_empty
    usup = 4'd0;
    uinf = 4'd8;
    step("thr_edge", 0, 0, '0, STATE_INIT);
    for (int j = 0; j < 3; j++) step("thr_push", 1, 0, DATA_W'(10'h2F0 + j), STATE_ACTIVE);
    usup = 4'd6;
    uinf = 4'd2;
    step("thr_back", 0, 1, '0, STATE_INIT);

    // async reset with a valid_out pending
    step("pend_pop", 0, 1, '0, STATE_ACTIVE);
    #2 reset_L = 1'b0;
    #1;
    model_reset();
    chk("midrst/valid", 32'(bus.valid_out), 32'd0);
    chk("midrst/data",  32'(bus.data_out),  32'd0);
    check_flags("midrst");
    @(negedge clk) reset_L = 1'b1;
    step("rst_idle", 0, 0, '0, STATE_IDLE);
    for (int j = 0; j < 6; j++) step("dflt_thr", 1, 0, DATA_W'(10'h011 + j), STATE_ACTIVE);
    for (int j = 0; j < 6; j++) step("dflt_drain", 0, 1, '0, STATE_ACTIVE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
